// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types for the ALU arbiter
// ALU opcodes and arbiter FSM states.
package alu_arb_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - combinational winner selection for the ALU arbiter
// Round-robin after i_last_grant; ALU_ARB_FIXED_PRIO_EN selects lowest-index-wins instead.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    // Descending scan so the lowest active index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = ID_W'(i);
      end
    end
    o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
  end
`else
  logic [ID_W:0] w_sum;
  logic [ID_W:0] w_cand;

  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    // Candidates last_grant+1 .. last_grant+NUM_REQ, wrapped without a divider.
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_sum  = {1'b0, i_last_grant} + (ID_W + 1)'(i);
      w_cand = (w_sum >= (ID_W + 1)'(NUM_REQ)) ? (w_sum - (ID_W + 1)'(NUM_REQ)) : w_sum;
      if (!o_any && i_req[w_cand[ID_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_cand[ID_W-1:0];
      end
    end
    o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one 16-bit ALU among NUM_REQ requesters
// Build option: ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [1:0]                alu_ctrl,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_lt,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_lt
);

  arb_state_t         r_state;
  alu_op_t            r_op;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_last_grant;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_result;
  logic               r_rsp_lt;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_pick (
    .i_req       (req_valid),
    .i_last_grant(r_last_grant),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_op         <= ALU_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_lt     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op         <= alu_op_t'(req_op[2*w_idx +: 2]);
            r_a          <= req_a[DATA_W*w_idx +: DATA_W];
            r_b          <= req_b[DATA_W*w_idx +: DATA_W];
            r_id         <= w_idx;
            r_last_grant <= w_idx;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= alu_result;
          // LT is only meaningful for a subtraction; other ops report 0.
          r_rsp_lt     <= (r_op == ALU_SUB) ? alu_lt : 1'b0;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE && reset_n) ? w_grant : '0;
  assign alu_ctrl   = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_id;
  assign rsp_result = r_rsp_result;
  assign rsp_lt     = r_rsp_lt;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 16-bit combinational ALU (ops ADD/SUB/AND/OR, LT flag) among NUM_REQ requesters.
- Round-robin selection, registered operands and registered result. One transaction in flight.
- Sits between issuing units and the ALU. Drives the ALU ctrl/operand inputs and samples alu_result/LT.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of rsp_id.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept, combinational, only in IDLE.
- req_op  in  2*NUM_REQ  per-requester op, slice i = [2i+1:2i].
- req_a  in  16*NUM_REQ  per-requester operand A, slice i = [16i+15:16i].
- req_b  in  16*NUM_REQ  per-requester operand B.
- alu_ctrl  out  2  to ALU ctrl.
- alu_a  out  16  to ALU input_a.
- alu_b  out  16  to ALU input_b.
- alu_result  in  16  from ALU.
- alu_lt  in  1  from ALU LT.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester served.
- rsp_result  out  16  captured ALU result.
- rsp_lt  out  1  captured LT.

Behaviour:
- FSM states:
  - IDLE: if any req_valid, pick winner g. req_ready[g]=1 this cycle. On the edge, latch op/a/b/id into operand regs, set last_grant=g, go to EXEC. No valid requests: stay in IDLE.
  - EXEC: alu_ctrl/alu_a/alu_b driven from operand regs. On the edge, capture alu_result into rsp_result. Capture rsp_lt = alu_lt when op==SUB, otherwise force rsp_lt to 0. Go to RESP.
  - RESP: rsp_valid=1. Outputs stay stable until rsp_valid && rsp_ready on an edge, then go to IDLE.
- Latency: accept at edge T, rsp_valid high after edge T+1, earliest completion at edge T+2. Peak throughput is one op per 3 cycles.
- Round-robin: search order is last_grant+1, +2, … modulo NUM_REQ. last_grant resets to NUM_REQ-1, so requester 0 wins first.
- req_ready is 0 in EXEC and RESP. Requesters hold valid/op/a/b stable until ready. The block samples only on the grant edge, so a dropped request is simply not granted.
- alu_* outputs come from the operand regs in every state (no combinational path from req_* to ALU).
- Arithmetic: 16-bit modulo, no carry or overflow output. ADD 0xFFFF+1 = 0x0000.
- Reset (asynchronous, any state): state=IDLE, rsp_valid=0, req_ready=0, operand regs/alu_*=0, rsp_result=0, rsp_lt=0, rsp_id=0, last_grant=NUM_REQ-1. An in-flight transaction is discarded with no response.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. last_grant is still recorded but unused for selection.
- Undefined: round-robin as above.
- Ports and latency are identical in both builds.

Decomposition:
- Package alu_arb_pkg:
  - DATA_W=16.
  - alu_op_t enum: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - arb_state_t enum: IDLE, EXEC, RESP.
- Sub-module rr_pick: combinational. Inputs are the request vector and last_grant. Outputs are the one-hot grant and the index. The ALU_ARB_FIXED_PRIO_EN selection lives here.

Test Plan:
- Req0 ADD 0x0003,0x0004, rsp_ready=1 → req_ready[0] one cycle; rsp_valid 2 edges later; rsp_result=0x0007, rsp_id=0, rsp_lt=0.
- Req2 SUB 0x0002,0x0005 → rsp_result=0xFFFD, rsp_lt=1. Req2 AND 0x8000,0xFFFF → 0x8000, rsp_lt=0 (non-SUB forced 0).
- All 4 req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0,1. With ALU_ARB_FIXED_PRIO_EN defined → 0,0,0,…
- Req1 OR 0xF0F0,0x0F0F with rsp_ready low 5 cycles → rsp_valid/rsp_result=0xFFFF/rsp_id=1 stable; all req_ready=0 until the handshake.
- Assert reset_n=0 mid-EXEC → rsp_valid=0 immediately; after release, req3 and req0 valid → req0 granted first.
- Req0 ADD 0xFFFF,0x0001 → rsp_result=0x0000, rsp_lt=0.
